mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8, maximum grant length in cycles before forced release; legal range 2..(2^CNT_W).
REQ-002 Parameter: CNT_W, 4, width of the grant-length counter.
REQ-003 iClk  input  1  single clock; all state updates on its rising edge.
REQ-004 iClr  input  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
REQ-005 iReq0  input  1  requester 0 wants the shared mux path; level, held for the whole transfer.
REQ-006 iReq1  input  1  requester 1 wants the shared mux path; level, held for the whole transfer.
REQ-007 oGnt0  output  1  requester 0 owns the path.
REQ-008 oGnt1  output  1  requester 1 owns the path.
REQ-009 oSel  output  1  drives mux iSel; 0 selects requester 0, 1 selects requester 1.
REQ-010 oEnb  output  1  drives mux iEnb; active-low, 0 = mux passes data, 1 = mux output forced 0.
REQ-011 oTimeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-012 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-013 FSM states shall be IDLE, GNT0, GNT1, GAP.
REQ-014 A 1-bit priority pointer shall name the preferred requester when both request; set to the non-granted requester on every grant entry.
REQ-015 IDLE: a request sampled at edge N shall put the FSM in GNTx with oGnt asserted after edge N (1-cycle latency); both requesting -> pointer wins; none -> stay IDLE.
REQ-016 GNTx: oGntx=1, other grant 0, oSel=x, oEnb=0; counter increments by 1 per cycle, starting at 0 on entry.
REQ-017 GNTx shall exit to GAP when iReqx is sampled 0 (voluntary release), or when the counter equals TIMEOUT-1 (forced release), whichever comes first.
REQ-018 On forced release oTimeout shall be 1 for exactly the first GAP cycle; voluntary release shall never assert it.
REQ-019 If iReqx drops on the same edge as the counter reaches TIMEOUT-1, the release shall count as voluntary (oTimeout stays 0).
REQ-020 GAP: exactly one cycle with both grants 0, oEnb=1, oSel holding its last value (break-before-make).
REQ-021 GAP exit: arbitrate as in IDLE, going directly to GNT0/GNT1, or to IDLE if no request.
REQ-022 After a forced release, a requester still asserting alone shall be re-granted after GAP; another pending requester shall be granted first.
REQ-023 oGnt0 and oGnt1 shall never be 1 simultaneously; oEnb=0 exactly when one grant is 1.
REQ-024 Counter shall not wrap; it is cleared on every grant entry and held at 0 outside GNTx.

Reset
REQ-025 iClr=0 shall immediately, independent of iClk, force: state IDLE, oGnt0=0, oGnt1=0, oSel=0, oEnb=1, oTimeout=0, counter 0, pointer = requester 0.
REQ-026 Reset asserted mid-grant shall drop the grant without a GAP cycle; first arbitration occurs on the first rising edge with iClr=1.

Verification (TIMEOUT=4)
REQ-027 Reset then iReq0=1 at edge 1 -> oGnt0=1, oSel=0, oEnb=0 after edge 1; iReq0=0 at edge 3 -> GAP (oEnb=1, oTimeout=0) then IDLE.
REQ-028 iReq0=iReq1=1 from reset -> grants in order 0,1,0,1, each 4 cycles long, separated by one GAP cycle each with oTimeout=1.
REQ-029 iReq1 held alone -> oGnt1 for 4 cycles, GAP with oTimeout=1, oGnt1 re-asserted next cycle.
REQ-030 iReq0 drops exactly on the 4th grant cycle -> GAP with oTimeout=0.
REQ-031 iClr pulled low during GNT1 between clock edges -> oGnt1=0, oEnb=1, oSel=0 before the next edge; with both requests pending after release, requester 0 is granted first.
REQ-032 Every scenario: checker asserts never (oGnt0 & oGnt1) and oEnb == ~(oGnt0 | oGnt1) on every cycle.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-requester arbiter for a shared mux path with a forced release after TIMEOUT cycles and a one-cycle break-before-make gap.
// Grant appears one cycle after the request is sampled, and all outputs are registered.
module mux_arbiter #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic iClk,
  input  logic iClr,
  input  logic iReq0,
  input  logic iReq1,
  output logic oGnt0,
  output logic oGnt1,
  output logic oSel,
  output logic oEnb,
  output logic oTimeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             ptr, ptrNxt;
  logic             forceRel;
  logic             gnt0Nxt, gnt1Nxt, selNxt, enbNxt, timeoutNxt;

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      ptr   <= ptrNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = '0;
    ptrNxt   = ptr;
    forceRel = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (iReq0 && iReq1) stateNxt = ptr ? GNT1 : GNT0;
        else if (iReq0)     stateNxt = GNT0;
        else if (iReq1)     stateNxt = GNT1;
        else                stateNxt = IDLE;
        // The pointer always names whoever did not win this arbitration.
        if (stateNxt == GNT0) ptrNxt = 1'b1;
        if (stateNxt == GNT1) ptrNxt = 1'b0;
      end
      GNT0, GNT1: begin
        // A dropped request wins over the timeout when both happen on the same edge.
        if ((state == GNT0) ? !iReq0 : !iReq1) begin
          stateNxt = GAP;
        end else if (cnt == CNT_LAST) begin
          stateNxt = GAP;
          forceRel = 1'b1;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0Nxt    = (stateNxt == GNT0);
    gnt1Nxt    = (stateNxt == GNT1);
    enbNxt     = !(gnt0Nxt || gnt1Nxt);
    selNxt     = gnt1Nxt ? 1'b1 : (gnt0Nxt ? 1'b0 : oSel);
    timeoutNxt = forceRel;
  end

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      oGnt0    <= 1'b0;
      oGnt1    <= 1'b0;
      oSel     <= 1'b0;
      oEnb     <= 1'b1;
      oTimeout <= 1'b0;
    end else begin
      oGnt0    <= gnt0Nxt;
      oGnt1    <= gnt1Nxt;
      oSel     <= selNxt;
      oEnb     <= enbNxt;
      oTimeout <= timeoutNxt;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with TIMEOUT=4: a vector table plus a hand-written mid-grant reset sequence.
module tb_mux_arbiter;

  logic iClk;
  logic iClr;
  logic iReq0;
  logic iReq1;
  logic oGnt0;
  logic oGnt1;
  logic oSel;
  logic oEnb;
  logic oTimeout;

  mux_arbiter #(.TIMEOUT(4), .CNT_W(4)) dut (
    .iClk    (iClk),
    .iClr    (iClr),
    .iReq0   (iReq0),
    .iReq1   (iReq1),
    .oGnt0   (oGnt0),
    .oGnt1   (oGnt1),
    .oSel    (oSel),
    .oEnb    (oEnb),
    .oTimeout(oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic clr;
    logic r0;
    logic r1;
    logic [4:0] exp;  // {gnt0, gnt1, sel, enb, timeout}
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void addN(input int n, input logic clr, input logic r0, input logic r1,
                               input logic g0, input logic g1, input logic sel,
                               input logic enb, input logic to);
    vec_t v;
    v.clr = clr;
    v.r0  = r0;
    v.r1  = r1;
    v.exp = {g0, g1, sel, enb, to};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic checkOut(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = {oGnt0, oGnt1, oSel, oEnb, oTimeout};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {gnt0,gnt1,sel,enb,to}=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkInv();
    total++;
    if ((oGnt0 & oGnt1) || (oEnb !== ~(oGnt0 | oGnt1))) begin
      bad++;
      $display("FAIL invariant: gnt0=%b gnt1=%b enb=%b want exclusive grants and enb=~(gnt0|gnt1) at %0t",
               oGnt0, oGnt1, oEnb, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
    checkInv();
  endtask

  initial begin
    iClr  = 1'b1;
    iReq0 = 1'b0;
    iReq1 = 1'b0;

    // Single request, voluntary release after two cycles, then idle.
    addN(2, 1, 1, 0, 1, 0, 0, 0, 0);
    addN(1, 1, 0, 0, 0, 0, 0, 1, 0);
    addN(2, 1, 0, 0, 0, 0, 0, 1, 0);
    // Both requesting from reset: 0,1,0,1 with forced-release gaps.
    addN(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      addN(4, 1, 1, 1, (k % 2) == 0, (k % 2) == 1, (k % 2) == 1, 0, 0);
      addN(1, 1, 1, 1, 0, 0, (k % 2) == 1, 1, 1);
    end
    // Requester 1 alone: timeout, re-grant, then voluntary release.
    addN(1, 0, 0, 0, 0, 0, 0, 1, 0);
    addN(4, 1, 0, 1, 0, 1, 1, 0, 0);
    addN(1, 1, 0, 1, 0, 0, 1, 1, 1);
    addN(1, 1, 0, 1, 0, 1, 1, 0, 0);
    addN(2, 1, 0, 0, 0, 0, 1, 1, 0);
    // Request drops on the same edge the counter hits its limit: voluntary.
    addN(1, 0, 0, 0, 0, 0, 0, 1, 0);
    addN(4, 1, 1, 0, 1, 0, 0, 0, 0);
    addN(2, 1, 0, 0, 0, 0, 0, 1, 0);

    #1;
    iClr = 1'b0;
    #2;
    checkOut("reset_async", 5'b00010);
    tick();
    checkOut("reset_held", 5'b00010);

    foreach (vecs[i]) begin
      iClr  = vecs[i].clr;
      iReq0 = vecs[i].r0;
      iReq1 = vecs[i].r1;
      tick();
      checkOut($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset pulled between edges during GNT1 with both requests pending.
    iClr  = 1'b1;
    iReq0 = 1'b0;
    iReq1 = 1'b1;
    tick();
    checkOut("mid_gnt1_a", 5'b01100);
    iReq0 = 1'b1;
    tick();
    checkOut("mid_gnt1_b", 5'b01100);
    #3;
    iClr = 1'b0;
    #1;
    checkOut("mid_rst_async", 5'b00010);
    tick();
    checkOut("mid_rst_held", 5'b00010);
    iClr = 1'b1;
    tick();
    checkOut("first_after_rst", 5'b10000);
    tick();
    checkOut("second_after_rst", 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
